// File: rtl/sifive_scope_frontend_resp_capture.sv
// Trigger-and-capture circular buffer that passively records frontend response beats.
// Optional per-entry 16-bit cycle timestamp: define SIFIVE_SCOPE_FRONTEND_TIMESTAMP_EN.
`timescale 1ns/1ps
module sifive_scope_frontend_resp_capture #(
  parameter int PC_W        = 32,
  parameter int FETCH_BYTES = 4,
  parameter int DEPTH       = 16,
  parameter int POST_TRIG   = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       arm,
  input  logic                       trig_xcpt_en,
  input  logic                       trig_pc_en,
  input  logic [PC_W-1:0]            trig_pc,
  input  logic                       mon_valid,
  input  logic                       mon_ready,
  input  logic [PC_W-1:0]            mon_pc,
  input  logic [8*FETCH_BYTES-1:0]   mon_data,
  input  logic [FETCH_BYTES/2-1:0]   mon_mask,
  input  logic                       mon_xcpt_pf,
  input  logic                       mon_xcpt_ae,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [PC_W-1:0]            rd_pc,
  output logic [8*FETCH_BYTES-1:0]   rd_data,
  output logic [FETCH_BYTES/2-1:0]   rd_mask,
  output logic                       rd_xcpt_pf,
  output logic                       rd_xcpt_ae,
`ifdef SIFIVE_SCOPE_FRONTEND_TIMESTAMP_EN
  output logic [15:0]                rd_timestamp,
`endif
  output logic                       armed,
  output logic                       triggered,
  output logic                       frozen,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int DATA_W = 8 * FETCH_BYTES;
  localparam int MASK_W = FETCH_BYTES / 2;
  localparam int EW     = 2 + MASK_W + DATA_W + PC_W;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_FROZEN} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   wptr_reg, wptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [AW-1:0]   post_reg, post_next;
  logic            armed_reg, triggered_reg, frozen_reg;
  logic            fire, hit, capture, pop;
  logic [AW-1:0]   rd_idx;
  logic [EW-1:0]   entry, rd_entry;
  logic [EW-1:0]   mem_reg [DEPTH];

  assign fire    = mon_valid & mon_ready;
  assign hit     = (trig_xcpt_en & (mon_xcpt_pf | mon_xcpt_ae)) |
                   (trig_pc_en & (mon_pc == trig_pc));
  assign capture = fire & ~arm & ((state_reg == S_ARMED) | (state_reg == S_POST));
  assign pop     = rd_valid & rd_ready & ~arm;
  assign entry   = {mon_xcpt_ae, mon_xcpt_pf, mon_mask, mon_data, mon_pc};

  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    count_next = count_reg;
    post_next  = post_reg;
    if (arm) begin
      state_next = S_ARMED;
      wptr_next  = '0;
      count_next = '0;
      post_next  = '0;
    end else begin
      if (capture) begin
        wptr_next  = wptr_reg + AW'(1);
        count_next = (count_reg == CW'(DEPTH)) ? count_reg : count_reg + CW'(1);
      end
      case (state_reg)
        S_ARMED: begin
          if (fire && hit) begin
            post_next  = AW'(POST_TRIG);
            state_next = (POST_TRIG == 0) ? S_FROZEN : S_POST;
          end
        end
        // Hits are ignored here: the post window never re-extends.
        S_POST: begin
          if (fire) begin
            post_next = post_reg - AW'(1);
            if (post_reg == AW'(1)) state_next = S_FROZEN;
          end
        end
        S_FROZEN: begin
          if (pop) count_next = count_reg - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      wptr_reg      <= '0;
      count_reg     <= '0;
      post_reg      <= '0;
      armed_reg     <= 1'b0;
      triggered_reg <= 1'b0;
      frozen_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wptr_reg      <= wptr_next;
      count_reg     <= count_next;
      post_reg      <= post_next;
      armed_reg     <= (state_next == S_ARMED) || (state_next == S_POST);
      triggered_reg <= (state_next == S_POST) || (state_next == S_FROZEN);
      frozen_reg    <= (state_next == S_FROZEN);
    end
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clock) begin
    if (capture) mem_reg[wptr_reg] <= entry;
  end

  // Oldest entry sits count places behind the write pointer.
  assign rd_idx   = wptr_reg - count_reg[AW-1:0];
  assign rd_entry = mem_reg[rd_idx];
  assign rd_valid = frozen_reg & (count_reg != '0);
  assign {rd_xcpt_ae, rd_xcpt_pf, rd_mask, rd_data, rd_pc} = rd_valid ? rd_entry : '0;

`ifdef SIFIVE_SCOPE_FRONTEND_TIMESTAMP_EN
  logic [15:0] ts_reg;
  logic [15:0] ts_mem_reg [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts_reg <= '0;
    else          ts_reg <= ts_reg + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (capture) ts_mem_reg[wptr_reg] <= ts_reg;
  end

  assign rd_timestamp = rd_valid ? ts_mem_reg[rd_idx] : '0;
`endif

  assign armed     = armed_reg;
  assign triggered = triggered_reg;
  assign frozen    = frozen_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_sifive_scope_frontend_resp_capture.sv
// Directed bench for the frontend response capture buffer (DEPTH=8, POST_TRIG=2).
`timescale 1ns/1ps
module tb_sifive_scope_frontend_resp_capture;
  localparam int PC_W = 32;
  localparam int FB = 4;
  localparam int DEPTH = 8;
  localparam int POST_TRIG = 2;
  localparam logic [31:0] DMASK = 32'hA5A5_0000;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic arm = 1'b0, trig_xcpt_en = 1'b0, trig_pc_en = 1'b0;
  logic [PC_W-1:0] trig_pc = '0;
  logic mon_valid = 1'b0, mon_ready = 1'b0;
  logic [PC_W-1:0] mon_pc = '0;
  logic [8*FB-1:0] mon_data = '0;
  logic [FB/2-1:0] mon_mask = '0;
  logic mon_xcpt_pf = 1'b0, mon_xcpt_ae = 1'b0;
  logic rd_valid, rd_ready = 1'b0;
  logic [PC_W-1:0] rd_pc;
  logic [8*FB-1:0] rd_data;
  logic [FB/2-1:0] rd_mask;
  logic rd_xcpt_pf, rd_xcpt_ae;
  logic armed, triggered, frozen;
  logic [$clog2(DEPTH):0] count;
`ifdef SIFIVE_SCOPE_FRONTEND_TIMESTAMP_EN
  logic [15:0] rd_timestamp;
  logic [15:0] ts0, ts1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sifive_scope_frontend_resp_capture #(
    .PC_W(PC_W), .FETCH_BYTES(FB), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .clock(clock), .reset_n(reset_n), .arm(arm),
    .trig_xcpt_en(trig_xcpt_en), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_pc(mon_pc),
    .mon_data(mon_data), .mon_mask(mon_mask),
    .mon_xcpt_pf(mon_xcpt_pf), .mon_xcpt_ae(mon_xcpt_ae),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_data(rd_data),
    .rd_mask(rd_mask), .rd_xcpt_pf(rd_xcpt_pf), .rd_xcpt_ae(rd_xcpt_ae),
`ifdef SIFIVE_SCOPE_FRONTEND_TIMESTAMP_EN
    .rd_timestamp(rd_timestamp),
`endif
    .armed(armed), .triggered(triggered), .frozen(frozen), .count(count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic a, input logic t,
                              input logic f, input int c);
    check_eq($sformatf("%s_armed", tag), 32'(armed), 32'(a));
    check_eq($sformatf("%s_triggered", tag), 32'(triggered), 32'(t));
    check_eq($sformatf("%s_frozen", tag), 32'(frozen), 32'(f));
    check_eq($sformatf("%s_count", tag), 32'(count), c);
  endtask

  // One monitored-channel cycle; returns 1ns after the capturing edge.
  task automatic beat(input logic [31:0] pc, input logic pf, input logic v,
                      input logic r, input logic a);
    @(negedge clock);
    arm = a; mon_valid = v; mon_ready = r; mon_pc = pc;
    mon_data = pc ^ DMASK; mon_mask = pc[3:2]; mon_xcpt_pf = pf; mon_xcpt_ae = 1'b0;
    @(posedge clock); #1;
    arm = 1'b0; mon_valid = 1'b0; mon_ready = 1'b0; mon_xcpt_pf = 1'b0;
    $display("beat pc=0x%0h v=%0b r=%0b pf=%0b arm=%0b", pc, v, r, pf, a);
  endtask

  task automatic fire(input logic [31:0] pc, input logic pf);
    beat(pc, pf, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] pc, input logic pf);
    @(negedge clock);
    check_eq($sformatf("%s_valid", tag), 32'(rd_valid), 32'd1);
    check_eq($sformatf("%s_pc", tag), rd_pc, pc);
    check_eq($sformatf("%s_data", tag), rd_data, pc ^ DMASK);
    check_eq($sformatf("%s_mask", tag), 32'(rd_mask), 32'(pc[3:2]));
    check_eq($sformatf("%s_pf", tag), 32'(rd_xcpt_pf), 32'(pf));
    rd_ready = 1'b1;
    @(posedge clock); #1;
    rd_ready = 1'b0;
    $display("pop pc=0x%0h pf=%0b", rd_pc, pf);
  endtask

  initial begin
    // Reset state
    #2 reset_n = 1'b0;
    #20;
    check_status("rst", 1'b0, 1'b0, 1'b0, 0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_pc", rd_pc, 32'd0);
    @(negedge clock) reset_n = 1'b1;

    // Exception trigger
    trig_xcpt_en = 1'b1;
    beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("t1_arm", 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) fire(32'h100 + 32'(4*k), 1'b0);
    fire(32'h110, 1'b1);
    check_status("t1_trig", 1'b1, 1'b1, 1'b0, 5);
    fire(32'h114, 1'b0);
    fire(32'h118, 1'b0);
    check_status("t1_frz", 1'b0, 1'b1, 1'b1, 7);
    for (int k = 0; k < 7; k++) pop_check("t1", 32'h100 + 32'(4*k), (k == 4));
    check_eq("t1_empty_valid", 32'(rd_valid), 32'd0);
    check_eq("t1_empty_count", 32'(count), 32'd0);
    trig_xcpt_en = 1'b0;

    // Wrap with PC trigger
    trig_pc_en = 1'b1; trig_pc = 32'h12C;
    beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 14; k++) fire(32'h100 + 32'(4*k), 1'b0);
    check_status("t2_frz", 1'b0, 1'b1, 1'b1, 8);
    for (int k = 0; k < 8; k++) pop_check("t2", 32'h118 + 32'(4*k), 1'b0);
    check_eq("t2_empty_valid", 32'(rd_valid), 32'd0);

    // Backpressure on both sides
    trig_pc = 32'h208;
    beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    fire(32'h200, 1'b0);
    beat(32'h204, 1'b0, 1'b1, 1'b0, 1'b0);
    check_status("t3_noready", 1'b1, 1'b0, 1'b0, 1);
    fire(32'h208, 1'b0);
    beat(32'h20C, 1'b0, 1'b0, 1'b1, 1'b0);
    check_status("t3_novalid", 1'b1, 1'b1, 1'b0, 2);
    fire(32'h210, 1'b0);
    fire(32'h214, 1'b0);
    check_status("t3_frz", 1'b0, 1'b1, 1'b1, 4);
    begin
      logic [31:0] exp_pc [4];
      exp_pc = '{32'h200, 32'h208, 32'h210, 32'h214};
      for (int k = 0; k < 4; k++) begin
        @(negedge clock); rd_ready = 1'b0;
        @(posedge clock); #1;
        check_eq("t3_stall_pc", rd_pc, exp_pc[k]);
        check_eq("t3_stall_count", 32'(count), 32'(4 - k));
        pop_check("t3", exp_pc[k], 1'b0);
      end
    end
    check_eq("t3_empty_valid", 32'(rd_valid), 32'd0);
    trig_pc_en = 1'b0;

    // Arm coincident with a hit in POST; no retrigger in POST
    trig_xcpt_en = 1'b1;
    beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    fire(32'h300, 1'b0);
    fire(32'h304, 1'b1);
    beat(32'h308, 1'b1, 1'b1, 1'b1, 1'b1);
    check_status("t4_rearm", 1'b1, 1'b0, 1'b0, 0);
    fire(32'h400, 1'b0);
    fire(32'h404, 1'b1);
    fire(32'h408, 1'b1);
    check_status("t4_post", 1'b1, 1'b1, 1'b0, 3);
    fire(32'h40C, 1'b0);
    check_status("t4_frz", 1'b0, 1'b1, 1'b1, 4);
    pop_check("t4", 32'h400, 1'b0);
    pop_check("t4", 32'h404, 1'b1);
    pop_check("t4", 32'h408, 1'b1);
    pop_check("t4", 32'h40C, 1'b0);

    // Asynchronous reset during POST
    beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    fire(32'h500, 1'b0);
    fire(32'h504, 1'b1);
    check_status("t5_post", 1'b1, 1'b1, 1'b0, 2);
    #1 reset_n = 1'b0;
    #1;
    check_status("t5_rst", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clock) reset_n = 1'b1;
    fire(32'h600, 1'b1);
    check_status("t5_idle", 1'b0, 1'b0, 1'b0, 0);
    beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("t5_arm", 1'b1, 1'b0, 1'b0, 0);

`ifdef SIFIVE_SCOPE_FRONTEND_TIMESTAMP_EN
    // Timestamps of fires three cycles apart
    fire(32'h700, 1'b0);
    beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    fire(32'h704, 1'b1);
    fire(32'h708, 1'b0);
    fire(32'h70C, 1'b0);
    check_status("t6_frz", 1'b0, 1'b1, 1'b1, 4);
    @(negedge clock); ts0 = rd_timestamp;
    pop_check("t6", 32'h700, 1'b0);
    @(negedge clock); ts1 = rd_timestamp;
    pop_check("t6", 32'h704, 1'b1);
    check_eq("t6_ts_delta", 32'(ts1 - ts0), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
